// File: rtl/div_iter_pkg.sv
// Shared CPU definitions for the iterative divider used by the EX stage:
// FSM encoding and the number of radix-2 steps per divide.
package div_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } divState_t;

    localparam int DIV_ITERS = 32;

endpackage

// File: rtl/div_iter.sv
// Multi-cycle restoring radix-2 divider for DIV/DIVU with fixed 33-cycle latency,
// valid/ready result handshake and EX-stage cancel.
module div_iter
    import div_iter_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        div_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        cancel,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output divState_t   dbgState
);

    // Handshake: a request is taken on a rising edge where start && in_ready && !cancel;
    // a result transfers on a rising edge where out_valid && out_ready && !cancel.
    // Both in_ready and out_valid are pure decodes of the state register.

    divState_t   state;
    divState_t   stateNext;
    logic [5:0]  iterCnt;
    logic [31:0] remReg;
    logic [31:0] quoReg;
    logic [31:0] divisorMag;
    logic [31:0] dividendOrig;
    logic        negQuot;
    logic        negRem;
    logic        divByZero;

    logic        accept;
    logic        lastStep;
    logic [32:0] shifted;
    logic        stepOk;
    logic [31:0] remNext;
    logic [31:0] quoNext;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [31:0] qFinal;
    logic [31:0] rFinal;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign dbgState  = state;

    assign accept   = start && (state == IDLE) && !cancel;
    assign lastStep = (iterCnt == 6'(DIV_ITERS));

    assign magA = (div_signed && dividend[31]) ? -dividend : dividend;
    assign magB = (div_signed && divisor[31])  ? -divisor  : divisor;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign shifted = {remReg, quoReg[31]};
    assign stepOk  = (shifted >= {1'b0, divisorMag});
    assign remNext = stepOk ? 32'(shifted - {1'b0, divisorMag}) : shifted[31:0];
    assign quoNext = {quoReg[30:0], stepOk};

    assign qFinal = divByZero ? 32'hFFFF_FFFF : (negQuot ? -quoReg : quoReg);
    assign rFinal = divByZero ? dividendOrig  : (negRem  ? -remReg : remReg);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    stateNext = CALC;
                end
            end
            CALC: begin
                if (cancel) begin
                    stateNext = IDLE;
                end else if (lastStep) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                if (cancel || out_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            iterCnt      <= 6'd0;
            remReg       <= 32'd0;
            quoReg       <= 32'd0;
            divisorMag   <= 32'd0;
            dividendOrig <= 32'd0;
            negQuot      <= 1'b0;
            negRem       <= 1'b0;
            divByZero    <= 1'b0;
            quotient     <= 32'd0;
            remainder    <= 32'd0;
        end else if (accept) begin
            iterCnt      <= 6'd0;
            remReg       <= 32'd0;
            quoReg       <= magA;
            divisorMag   <= magB;
            dividendOrig <= dividend;
            negQuot      <= div_signed && (dividend[31] ^ divisor[31]);
            negRem       <= div_signed && dividend[31];
            divByZero    <= (divisor == 32'd0);
        end else if (state == CALC && !cancel) begin
            if (!lastStep) begin
                remReg  <= remNext;
                quoReg  <= quoNext;
                iterCnt <= iterCnt + 6'd1;
            end else begin
                // Sign fix-up lands in the output registers on the CALC->DONE edge.
                quotient  <= qFinal;
                remainder <= rFinal;
            end
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed vector table, handshake/cancel/reset
// sequences and randomized operands against an arithmetic reference model.
module tb_div_iter;
    import div_iter_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    divState_t   dbgState;

    int nChecks = 0;
    int nPass   = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[12];

    div_iter dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .div_signed (div_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .cancel     (cancel),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .dbgState   (dbgState)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, with the architectural divide-by-zero result.
    function automatic logic [63:0] refModel(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) begin
            return {32'hFFFF_FFFF, a};
        end
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        q = sa / sb;
        r = sa % sb;
        return {q[31:0], r[31:0]};
    endfunction

    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        check("in_ready before start", 32'(in_ready), 32'd1);
        start      = 1'b1;
        div_signed = sgn;
        dividend   = a;
        divisor    = b;
        @(posedge clk);
        #1;
        start      = 1'b0;
        div_signed = 1'($urandom_range(0, 1));
        dividend   = $urandom();
        divisor    = $urandom();
    endtask

    task automatic waitValid(output int cycles, output bit sawReady);
        cycles   = 0;
        sawReady = 1'b0;
        while (!out_valid && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            if (in_ready) sawReady = 1'b1;
        end
    endtask

    task automatic collect(input string name, input int holdCycles);
        int cycles;
        bit sawReady;
        logic [63:0] exp;
        waitValid(cycles, sawReady);
        check({name, " latency"}, 32'(cycles), 32'd33);
        check({name, " in_ready low in flight"}, 32'(sawReady), 32'd0);
        if (exp_q.size() == 0) begin
            check({name, " expected queue empty"}, 32'd1, 32'd0);
            exp = 64'd0;
        end else begin
            exp = exp_q.pop_front();
        end
        check({name, " quotient"}, quotient, exp[63:32]);
        check({name, " remainder"}, remainder, exp[31:0]);
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk);
            #1;
            check({name, " hold out_valid"}, 32'(out_valid), 32'd1);
            check({name, " hold quotient"}, quotient, exp[63:32]);
            check({name, " hold remainder"}, remainder, exp[31:0]);
            check({name, " hold in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, " in_ready after consume"}, 32'(in_ready), 32'd1);
        check({name, " out_valid after consume"}, 32'(out_valid), 32'd0);
    endtask

    task automatic watchNoValid(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check({name, " no out_valid"}, 32'(seen), 32'd0);
    endtask

    initial begin
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;
        int          cycles;
        bit          sawReady;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
        vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
        vecs[4]  = '{1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234};
        vecs[5]  = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB};
        vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
        vecs[7]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};
        vecs[8]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE};
        vecs[9]  = '{1'b0, 32'd5,          32'd7,          32'd0,          32'd5};
        vecs[10] = '{1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0};
        vecs[11] = '{1'b0, 32'hFFFF_FFFF,  32'h0001_0000,  32'h0000_FFFF,  32'h0000_FFFF};

        resetn     = 1'b0;
        start      = 1'b0;
        div_signed = 1'b0;
        dividend   = 32'd0;
        divisor    = 32'd0;
        cancel     = 1'b0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset state", 32'(dbgState), 32'(IDLE));
        resetn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            exp_q.push_back({vecs[i].q, vecs[i].r});
            issue(vecs[i].sgn, vecs[i].a, vecs[i].b);
            collect($sformatf("vec%0d", i), (i == 0) ? 5 : 0);
        end

        // Cancel together with start in IDLE must not accept.
        @(negedge clk);
        start  = 1'b1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cancel = 1'b0;
        check("idle cancel beats start", 32'(in_ready), 32'd1);

        // Cancel at cycle 10 of CALC with start high, then a clean DIVU 9/3.
        issue(1'b0, 32'd50, 32'd5);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        cancel   = 1'b1;
        start    = 1'b1;
        dividend = 32'd77;
        divisor  = 32'd11;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        start  = 1'b0;
        check("calc cancel in_ready", 32'(in_ready), 32'd1);
        check("calc cancel out_valid", 32'(out_valid), 32'd0);
        watchNoValid("after cancel", 40);
        exp_q.push_back({32'd3, 32'd0});
        issue(1'b0, 32'd9, 32'd3);
        collect("divu 9/3", 0);

        // Cancel in DONE beats out_ready; result registers keep last value.
        issue(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
        waitValid(cycles, sawReady);
        check("done cancel latency", 32'(cycles), 32'd33);
        cancel    = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        cancel    = 1'b0;
        out_ready = 1'b0;
        check("done cancel out_valid", 32'(out_valid), 32'd0);
        check("done cancel in_ready", 32'(in_ready), 32'd1);
        check("done cancel quotient kept", quotient, 32'd14);
        check("done cancel remainder kept", remainder, 32'hFFFF_FFFE);

        // Reset at cycle 20 of CALC.
        issue(1'b1, 32'd1000, 32'd3);
        repeat (19) begin
            @(posedge clk);
            #1;
        end
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        check("mid reset in_ready", 32'(in_ready), 32'd1);
        check("mid reset out_valid", 32'(out_valid), 32'd0);
        check("mid reset quotient", quotient, 32'd0);
        check("mid reset remainder", remainder, 32'd0);
        check("mid reset state", 32'(dbgState), 32'(IDLE));
        watchNoValid("after reset", 40);

        for (int n = 0; n < 1000; n++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom();
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                b = 32'd0;
            end else if (sel <= 3) begin
                b = 32'($urandom_range(1, 15));
                if (sgn && $urandom_range(0, 1) == 1) b = -b;
            end else begin
                b = $urandom();
            end
            if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
            exp_q.push_back(refModel(sgn, a, b));
            issue(sgn, a, b);
            collect($sformatf("rnd%0d", n), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
